// File: rtl/adder_sched_pkg.sv
// Shared constants, FSM states and the tag that tracks each request through the adder pipeline.
package adder_sched_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned ADD_LAT_DEF = 2;

  // Tag ID is sized for the largest supported requester count so one struct serves every build.
  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned ID_W      = $clog2(N_REQ_MAX);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/adder_req_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     mask;
  logic [N-1:0]     hi_req;
  logic [N-1:0]     pick;
  logic             found;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (PTR_W'(i) >= ptr_q);
    end
  end

  assign hi_req = req & mask;
  assign pick   = (|hi_req) ? hi_req : req;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_req_scheduler.sv
// Shares one pipelined adder between N_REQ requesters; a tag pipe routes each result
// back to its issuer, and a drain sequence empties the pipeline on demand.
module adder_req_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]            req_cin,
  output logic [N_REQ-1:0]            req_ready,
  output logic [WIDTH-1:0]            add_a,
  output logic [WIDTH-1:0]            add_b,
  output logic                        add_cin,
  input  logic [WIDTH-1:0]            add_sum,
  input  logic                        add_cout,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_cout,
  input  logic                        drain,
  output logic                        drain_done,
  output logic                        busy
);

  localparam int unsigned CNT_W = $clog2(ADD_LAT + 3);

  sched_state_t      state_q, state_d;
  logic              run_en;
  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic [ID_W-1:0]   gnt_id;
  logic [WIDTH-1:0]  a_sel, b_sel;
  logic              cin_sel;
  logic [WIDTH-1:0]  add_a_q, add_b_q;
  logic              add_cin_q;
  tag_t              tag_q [ADD_LAT+1];
  logic              rsp_fire;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [WIDTH-1:0]  rsp_sum_q;
  logic              rsp_cout_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              drain_done_q;

  // Grants only in RUN; reset also masks the combinational ready path.
  assign run_en  = (state_q == RUN) && reset;
  assign arb_req = run_en ? req_valid : '0;
  assign accept  = |grant;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (reset),
    .req    (arb_req),
    .advance(accept),
    .grant  (grant)
  );

  always_comb begin
    gnt_id  = '0;
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_id  = ID_W'(i);
        a_sel   = req_a[i];
        b_sel   = req_b[i];
        cin_sel = req_cin[i];
      end
    end
  end

  // Operand registers hold between accepts; stale adder output is ignored via the tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else if (accept) begin
      add_a_q   <= a_sel;
      add_b_q   <= b_sel;
      add_cin_q <= cin_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k <= ADD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, id: gnt_id};
      for (int unsigned k = 1; k <= ADD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign rsp_fire = tag_q[ADD_LAT].valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire ? (N_REQ'(1) << tag_q[ADD_LAT].id) : '0;
      if (rsp_fire) begin
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = drain ? DRAIN : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= (state_d == DONE);
    end
  end

  assign req_ready  = grant;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign drain_done = drain_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adder_req_scheduler.sv
// Scoreboard bench: accepts push expected results, a monitor pops them as responses appear.
module tb_adder_req_scheduler;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0]        req_cin;
  logic [N-1:0]        req_ready;
  logic [W-1:0]        add_a, add_b, add_sum;
  logic                add_cin, add_cout;
  logic [N-1:0]        rsp_valid;
  logic [W-1:0]        rsp_sum;
  logic                rsp_cout;
  logic                drain = 1'b0;
  logic                drain_done, busy;

  adder_req_scheduler #(.N_REQ(N), .WIDTH(W), .ADD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .drain(drain), .drain_done(drain_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder standing beside the scheduler: LAT register stages, no reset.
  logic [W:0] apipe [1:LAT];
  always @(posedge clk) begin
    apipe[1] <= (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);
    for (int k = 2; k <= LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[LAT][W-1:0];
  assign add_cout = apipe[LAT][W];

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   nacc = 0;
  int   nrsp = 0;
  int   ndone = 0;
  bit   chk_arb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference arbitration: first valid requester scanning cyclically from p.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[IW'(j)]) return N'(1) << j;
    end
    return '0;
  endfunction

  always @(negedge clk) begin : mon
    exp_t         e;
    logic [N-1:0] acc;
    logic [W:0]   r;
    if (!reset) begin
      chk("reset_outputs", 32'({req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum,
                                rsp_cout, drain_done, busy}), 32'd0);
      sb.delete();
      mptr = 0;
      nacc = 0;
      nrsp = 0;
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected got=%b required=none t=%0t", rsp_valid, $time);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_valid), 32'(N'(1) << e.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
          nrsp++;
        end
      end
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (drain_done) begin
        ndone++;
        chk("drain_done_empty", 32'(sb.size()), 32'd0);
      end
      if (chk_arb) chk("grant", 32'(req_ready), 32'(rr_pick(req_valid, mptr)));
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[IW'(i)]) begin
          r = (W+1)'(req_a[IW'(i)]) + (W+1)'(req_b[IW'(i)]) + (W+1)'(req_cin[IW'(i)]);
          e.id = i;
          e.sum = r[W-1:0];
          e.cout = r[W];
          e.due = cyc + LAT + 2;
          sb.push_back(e);
          nacc++;
          mptr = (i + 1) % N;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[IW'(i)]   = W'($urandom);
      req_b[IW'(i)]   = W'($urandom);
      req_cin[IW'(i)] = 1'($urandom);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nrsp0;
    bit  got_done;
    req_valid = '1;
    req_a     = '1;
    req_b     = '1;
    req_cin   = '1;
    #26;
    reset   = 1'b1;
    chk_arb = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(req_ready), 32'h1);
    // Eight accepts under full contention with all-ones operands.
    repeat (8) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle("contention_idle");
    chk("contention_count", 32'(nrsp), 32'd8);

    step();
    req_valid  = 4'b0100;
    req_a[2]   = 4'b0101;
    req_b[2]   = 4'b0011;
    req_cin[2] = 1'b1;
    step();
    req_valid = '0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_sum", 32'(rsp_sum), 32'h9);
    chk("single_rsp_cout", 32'(rsp_cout), 32'h0);
    wait_idle("single_idle");

    for (int c = 0; c < 300; c++) begin
      step();
      req_valid = N'($urandom);
      rand_ops();
    end
    step();
    req_valid = '0;
    wait_idle("random_idle");
    chk("random_no_loss", 32'(nrsp), 32'(nacc));

    for (int c = 0; c < 40; c++) begin
      step();
      req_valid = (c % 2 == 0) ? 4'b1010 : 4'b1000;
      rand_ops();
    end
    step();
    req_valid = '0;
    wait_idle("gaps_idle");
    chk("gaps_no_loss", 32'(nrsp), 32'(nacc));

    // Drain with three operations in flight.
    nrsp0 = nrsp;
    ndone = 0;
    step();
    req_valid = 4'b0111;
    rand_ops();
    step();
    step();
    drain   = 1'b1;
    chk_arb = 1'b0;
    step();
    @(negedge clk);
    chk("drain_ready_low", 32'(req_ready), 32'd0);
    chk("drain_inflight", 32'(sb.size()), 32'd3);
    req_valid = '0;
    got_done = 1'b0;
    for (int k = 0; k < 30 && !got_done; k++) begin
      @(negedge clk);
      if (drain_done) begin
        got_done = 1'b1;
        drain = 1'b0;
      end
    end
    drain = 1'b0;
    chk("drain_done_seen", 32'(got_done), 32'd1);
    chk("drain_rsp_count", 32'(nrsp - nrsp0), 32'd3);
    @(negedge clk);
    chk("drain_done_width", 32'(drain_done), 32'd0);
    chk("drain_done_count", 32'(ndone), 32'd1);
    step();
    chk_arb = 1'b1;
    req_valid = 4'b0001;
    rand_ops();
    @(negedge clk);
    chk("resume_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    wait_idle("resume_idle");

    // Reset one cycle after an accept: the operation must vanish.
    step();
    req_valid = 4'b0010;
    rand_ops();
    step();
    req_valid = '0;
    @(negedge clk);
    chk("midreset_inflight", 32'(busy), 32'd1);
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_no_rsp", 32'(nrsp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
